// File: rtl/muldiv_seq_div_pkg.sv
// Shared definitions for the execute-stage sequential divider.
// Holds the ALU control encodings, the divider FSM state encoding and a helper function.
package muldiv_seq_div_pkg;

  // ALU control codes shared with the combinational ALU
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_AND    = 5'b00010;
  localparam logic [4:0] ALU_OR     = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SLL    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_SLT    = 5'b01000;
  localparam logic [4:0] ALU_SLTU   = 5'b01001;
  localparam logic [4:0] ALU_MUL    = 5'b01010;
  localparam logic [4:0] ALU_MULH   = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_MULHU  = 5'b01101;
  localparam logic [4:0] ALU_DIV    = 5'b10000;
  localparam logic [4:0] ALU_DIVU   = 5'b10001;
  localparam logic [4:0] ALU_REM    = 5'b10010;
  localparam logic [4:0] ALU_REMU   = 5'b10011;

  // Divider FSM state encoding
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_CALC_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_ENC,
    S_CALC = ST_CALC_ENC,
    S_DONE = ST_DONE_ENC
  } div_state_t;

  // True for the four control codes this block executes
  function automatic logic is_div_op(input logic [4:0] c);
    return (c == ALU_DIV) || (c == ALU_DIVU) || (c == ALU_REM) || (c == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq_div_div_step.sv
// One restoring division iteration on unsigned magnitudes.
// Shifts {rem, quo} left by one, trial-subtracts the divisor and restores on borrow.
module muldiv_seq_div_div_step
  import muldiv_seq_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  // The trial difference is one bit wider so its MSB is the borrow/sign.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};

  // Keep the difference when non-negative, otherwise restore the shifted value.
  assign rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_seq_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Runs XLEN restoring steps on magnitudes, then applies the sign fixup into res.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
module muldiv_seq_div
  import muldiv_seq_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      ctrl,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic [CW-1:0]   cnt;
  logic            op_rem;
  logic            neg_q;
  logic            neg_r;

  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  logic            accept;
  logic            is_signed;
  logic            is_rem;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] final_res;

  // Negate a magnitude when the latched result sign is set
  function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Request decode: ctrl[0] selects unsigned, ctrl[1] selects remainder
  assign accept    = start && is_div_op(ctrl);
  assign is_signed = ~ctrl[0];
  assign is_rem    = ctrl[1];
  assign div_zero  = (op2 == '0);
  assign sgn_ovf   = is_signed && (op1 == MOST_NEG) && (op2 == '1);

  // The most-negative dividend maps to 2^(XLEN-1), which fits unsigned.
  assign mag1 = (is_signed && op1[XLEN-1]) ? (~op1 + 1'b1) : op1;
  assign mag2 = (is_signed && op2[XLEN-1]) ? (~op2 + 1'b1) : op2;

  assign special_res = div_zero ? (is_rem ? op1 : '1)
                                : (is_rem ? '0  : op1);

  assign final_res = op_rem ? fix_sign(rem_q, neg_r) : fix_sign(quo_q, neg_q);

  assign busy = (state != S_IDLE);

  muldiv_seq_div_div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvsr    (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Control FSM, iteration datapath and registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      valid  <= 1'b0;
      res    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt    <= '0;
      op_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid <= 1'b0;
          if (accept) begin
            if (div_zero || sgn_ovf) begin
              res   <= special_res;
              valid <= 1'b1;
              state <= S_DONE;
            end else begin
              rem_q  <= '0;
              quo_q  <= mag1;
              dvsr_q <= mag2;
              cnt    <= CW'(XLEN);
              op_rem <= is_rem;
              neg_q  <= is_signed && (op1[XLEN-1] ^ op2[XLEN-1]);
              neg_r  <= is_signed && op1[XLEN-1];
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt != '0) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt - 1'b1;
          end else begin
            res   <= final_res;
            valid <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          valid <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          valid <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_div.sv
// Testbench for muldiv_seq_div: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_muldiv_seq_div;

  localparam logic [4:0] C_DIV  = 5'b10000;
  localparam logic [4:0] C_DIVU = 5'b10001;
  localparam logic [4:0] C_REM  = 5'b10010;
  localparam logic [4:0] C_REMU = 5'b10011;
  localparam int NORMAL_LAT = 33;
  localparam int WAIT_LIMIT = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [4:0]  ctrl;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        valid;
  logic [31:0] res;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_seq_div #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .ctrl  (ctrl),
    .op1   (op1),
    .op2   (op2),
    .busy  (busy),
    .valid (valid),
    .res   (res)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M division semantics using wide signed integer arithmetic
  function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    case (c)
      C_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        r = sa / sb;
        return r[31:0];
      end
      C_DIVU: return (b == 0) ? 32'hFFFF_FFFF : (a / b);
      C_REM: begin
        if (b == 0) return a;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 0) ? a : (a % b);
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (c == C_DIV) || (c == C_REM);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one operation and check busy, latency, result and the single-cycle valid
  task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int n;
    int exp_lat;
    exp_lat = is_special(c, a, b) ? 0 : NORMAL_LAT;
    @(negedge clk);
    start = 1'b1; ctrl = c; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!valid && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, res, exp);
    last_res = exp;
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, {31'b0, valid}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [4:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;
    int sel;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    ctrl = '0; op1 = '0; op2 = '0; last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'b0, busy},  32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_res",   res,            32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed arithmetic
    do_op(C_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7");
    do_op(C_REMU, 32'd100, 32'd7, 32'd2,  "remu_100_7");
    do_op(C_DIV,  -32'sd100, 32'd7, 32'hFFFF_FFF2, "div_m100_7");
    do_op(C_REM,  -32'sd100, 32'd7, 32'hFFFF_FFFE, "rem_m100_7");
    do_op(C_REM,  32'd100, -32'sd7, 32'd2, "rem_100_m7");

    // Divide by zero
    do_op(C_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "dz_div");
    do_op(C_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "dz_divu");
    do_op(C_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, "dz_rem");
    do_op(C_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, "dz_remu");

    // Signed overflow and its unsigned counterpart
    do_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "ovf_div");
    do_op(C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "ovf_rem");
    do_op(C_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "ovf_divu");

    // Most-negative dividend on a normal signed divide
    do_op(C_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, "mneg_div2");

    // Flush in CALC: no pulse, res kept
    @(negedge clk);
    start = 1'b1; ctrl = C_DIVU; op1 = 32'd65535; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy",  {31'b0, busy},  32'd0);
    check("flush_valid", {31'b0, valid}, 32'd0);
    check("flush_res_kept", res, last_res);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("flush_no_pulse", 32'(pulses), 32'd0);
    do_op(C_DIVU, 32'd9, 32'd3, 32'd3, "after_flush");

    // Flush wins over start on the same edge
    @(negedge clk);
    start = 1'b1; flush = 1'b1; ctrl = C_DIVU; op1 = 32'd9; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_prio_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("flush_prio_valid", {31'b0, valid}, 32'd0);

    // Non-divide control code is ignored
    @(negedge clk);
    start = 1'b1; ctrl = 5'b00001; op1 = 32'd50; op2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("badctrl_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("badctrl_valid", {31'b0, valid}, 32'd0);

    // Second start during CALC is ignored
    @(negedge clk);
    start = 1'b1; ctrl = C_DIVU; op1 = 32'd1000; op2 = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    start = 1'b1; ctrl = C_DIV; op1 = 32'd77; op2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n++;
    while (!valid && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart_lat", 32'(n), 32'(NORMAL_LAT));
    check("restart_res", res, 32'd100);
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; ctrl = C_DIVU; op1 = 32'd500; op2 = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy",  {31'b0, busy},  32'd0);
    check("arst_valid", {31'b0, valid}, 32'd0);
    check("arst_res",   res,            32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("arst_no_pulse", 32'(pulses), 32'd0);

    // Randomized operations against the reference model
    for (int k = 0; k < 30; k++) begin
      rc  = C_DIV + 5'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = -32'($urandom_range(1, 15));
      else               rb = $urandom >> $urandom_range(0, 31);
      do_op(rc, ra, rb, model(rc, ra, rb), $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
